// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter/splitter family.
package axis_pkg;

   localparam int unsigned NUM_OUTPUTS = 3;
   localparam int unsigned INDEX_WIDTH = 2;

   typedef enum logic [INDEX_WIDTH-1:0] {
      SEL_0 = 2'd0,
      SEL_1 = 2'd1,
      SEL_2 = 2'd2
   } sel_t;

   // Round-robin successor of a valid selection.
   function automatic sel_t next_sel(input sel_t cur);
      case (cur)
         SEL_0:   return SEL_1;
         SEL_1:   return SEL_2;
         default: return SEL_0;
      endcase
   endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough queue: the head entry is presented on dout
// whenever the queue is not empty.
module fallthrough_small_fifo #(
   parameter int unsigned WIDTH          = 72,
   parameter int unsigned MAX_DEPTH_BITS = 4
) (
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty,
   input  logic             reset,
   input  logic             clk
);

   localparam logic [MAX_DEPTH_BITS:0]   DEPTH    = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
   localparam logic [MAX_DEPTH_BITS:0]   NF_LEVEL = DEPTH - 1'b1;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE  = {{MAX_DEPTH_BITS{1'b0}}, 1'b1};
   localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = {{(MAX_DEPTH_BITS-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]          mem [2**MAX_DEPTH_BITS];
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS:0]   depth;
   logic                      full;
   logic                      push;
   logic                      pop;

   assign full        = (depth == DEPTH);
   assign empty       = (depth == '0);
   assign nearly_full = (depth >= NF_LEVEL);
   assign push        = wr_en & ~full;
   assign pop         = rd_en & ~empty;
   assign dout        = mem[rd_ptr];

   // Storage array; no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         depth  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      depth <= depth + CNT_ONE;
         else if (pop && !push) depth <= depth - CNT_ONE;
      end
   end

endmodule

// File: rtl/axis_1_to_3_splitter.sv
// Distributes whole packets from one AXI-Stream input round-robin over three
// AXI-Stream outputs, each behind its own fallthrough queue.
module axis_1_to_3_splitter
   import axis_pkg::*;
#(
   parameter int unsigned TDATA_WIDTH      = 256,
   parameter int unsigned TUSER_WIDTH      = 128,
   parameter int unsigned QUEUE_DEPTH_BITS = 4,
   localparam int unsigned TKEEP_WIDTH     = TDATA_WIDTH / 8
) (
   input  logic                   axis_aclk,
   input  logic                   axis_reset,

   input  logic [TDATA_WIDTH-1:0] axis_input_tdata,
   input  logic [TKEEP_WIDTH-1:0] axis_input_tkeep,
   input  logic [TUSER_WIDTH-1:0] axis_input_tuser,
   input  logic                   axis_input_tvalid,
   input  logic                   axis_input_tlast,
   output logic                   axis_input_tready,

   output logic [TDATA_WIDTH-1:0] axis_output_0_tdata,
   output logic [TKEEP_WIDTH-1:0] axis_output_0_tkeep,
   output logic [TUSER_WIDTH-1:0] axis_output_0_tuser,
   output logic                   axis_output_0_tvalid,
   output logic                   axis_output_0_tlast,
   input  logic                   axis_output_0_tready,

   output logic [TDATA_WIDTH-1:0] axis_output_1_tdata,
   output logic [TKEEP_WIDTH-1:0] axis_output_1_tkeep,
   output logic [TUSER_WIDTH-1:0] axis_output_1_tuser,
   output logic                   axis_output_1_tvalid,
   output logic                   axis_output_1_tlast,
   input  logic                   axis_output_1_tready,

   output logic [TDATA_WIDTH-1:0] axis_output_2_tdata,
   output logic [TKEEP_WIDTH-1:0] axis_output_2_tkeep,
   output logic [TUSER_WIDTH-1:0] axis_output_2_tuser,
   output logic                   axis_output_2_tvalid,
   output logic                   axis_output_2_tlast,
   input  logic                   axis_output_2_tready,

   output logic [31:0]            packet_count_0,
   output logic [31:0]            packet_count_1,
   output logic [31:0]            packet_count_2
);

   localparam int unsigned FIFO_WIDTH = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;

   sel_t                   current_output;
   sel_t                   next_output;
   logic                   sel_nearly_full;
   logic                   accept;

   logic                   staged_valid;
   logic [INDEX_WIDTH-1:0] staged_target;
   logic [FIFO_WIDTH-1:0]  staged_word;

   logic [NUM_OUTPUTS-1:0] q_nearly_full;
   logic [NUM_OUTPUTS-1:0] q_empty;
   logic [NUM_OUTPUTS-1:0] q_wr;
   logic [NUM_OUTPUTS-1:0] q_rd;
   logic [NUM_OUTPUTS-1:0] out_ready;
   logic [FIFO_WIDTH-1:0]  q_dout [NUM_OUTPUTS];
   logic [31:0]            pkt_count [NUM_OUTPUTS];

   assign out_ready = {axis_output_2_tready, axis_output_1_tready, axis_output_0_tready};

   // Only the currently selected queue may throttle the input; an invalid
   // selection encoding blocks input until the FSM recovers.
   always_comb begin
      sel_nearly_full = 1'b1;
      case (current_output)
         SEL_0:   sel_nearly_full = q_nearly_full[0];
         SEL_1:   sel_nearly_full = q_nearly_full[1];
         SEL_2:   sel_nearly_full = q_nearly_full[2];
         default: sel_nearly_full = 1'b1;
      endcase
   end

   assign axis_input_tready = ~sel_nearly_full & ~axis_reset;
   assign accept            = axis_input_tvalid & axis_input_tready;

   // Selection state register.
   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) current_output <= SEL_0;
      else            current_output <= next_output;
   end

   // Advance the selection only at the end of an accepted packet.
   always_comb begin
      next_output = current_output;
      case (current_output)
         SEL_0, SEL_1, SEL_2: begin
            if (accept && axis_input_tlast) next_output = next_sel(current_output);
         end
         default: next_output = SEL_0;
      endcase
   end

   // Staging register: holds the accepted beat and its destination for one cycle.
   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) begin
         staged_valid  <= 1'b0;
         staged_target <= '0;
         staged_word   <= '0;
      end else begin
         staged_valid <= accept;
         if (accept) begin
            staged_target <= current_output;
            staged_word   <= {axis_input_tlast, axis_input_tuser,
                              axis_input_tkeep, axis_input_tdata};
         end
      end
   end

   for (genvar n = 0; n < NUM_OUTPUTS; n++) begin : g_out
      assign q_wr[n] = staged_valid && (staged_target == INDEX_WIDTH'(n));
      assign q_rd[n] = ~q_empty[n] & out_ready[n];

      fallthrough_small_fifo #(
         .WIDTH          (FIFO_WIDTH),
         .MAX_DEPTH_BITS (QUEUE_DEPTH_BITS)
      ) u_queue (
         .din         (staged_word),
         .wr_en       (q_wr[n]),
         .rd_en       (q_rd[n]),
         .dout        (q_dout[n]),
         .nearly_full (q_nearly_full[n]),
         .empty       (q_empty[n]),
         .reset       (axis_reset),
         .clk         (axis_aclk)
      );

      // Count packets as their last beat enters the queue.
      always_ff @(posedge axis_aclk or posedge axis_reset) begin
         if (axis_reset)                                  pkt_count[n] <= '0;
         else if (q_wr[n] && staged_word[FIFO_WIDTH-1])   pkt_count[n] <= pkt_count[n] + 32'd1;
      end
   end

   assign {axis_output_0_tlast, axis_output_0_tuser, axis_output_0_tkeep, axis_output_0_tdata} = q_dout[0];
   assign {axis_output_1_tlast, axis_output_1_tuser, axis_output_1_tkeep, axis_output_1_tdata} = q_dout[1];
   assign {axis_output_2_tlast, axis_output_2_tuser, axis_output_2_tkeep, axis_output_2_tdata} = q_dout[2];

   assign axis_output_0_tvalid = ~q_empty[0];
   assign axis_output_1_tvalid = ~q_empty[1];
   assign axis_output_2_tvalid = ~q_empty[2];

   assign packet_count_0 = pkt_count[0];
   assign packet_count_1 = pkt_count[1];
   assign packet_count_2 = pkt_count[2];

endmodule

// File: tb/tb_axis_1_to_3_splitter.sv
// Directed bench for axis_1_to_3_splitter with per-output beat monitors.
module tb_axis_1_to_3_splitter;

   localparam int TDW = 256;
   localparam int TKW = 32;
   localparam int TUW = 128;
   localparam int FW  = TDW + TKW + TUW + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [TDW-1:0] in_data = '0;
   logic [TKW-1:0] in_keep = '0;
   logic [TUW-1:0] in_user = '0;
   logic           in_valid = 1'b0;
   logic           in_last = 1'b0;
   logic           in_ready;

   logic [TDW-1:0] o0_data, o1_data, o2_data;
   logic [TKW-1:0] o0_keep, o1_keep, o2_keep;
   logic [TUW-1:0] o0_user, o1_user, o2_user;
   logic           o0_valid, o1_valid, o2_valid;
   logic           o0_last, o1_last, o2_last;
   logic           o0_ready = 1'b1, o1_ready = 1'b1, o2_ready = 1'b1;
   logic [31:0]    cnt0, cnt1, cnt2;

   axis_1_to_3_splitter #(
      .TDATA_WIDTH      (TDW),
      .TUSER_WIDTH      (TUW),
      .QUEUE_DEPTH_BITS (4)
   ) dut (
      .axis_aclk            (clk),
      .axis_reset           (rst),
      .axis_input_tdata     (in_data),
      .axis_input_tkeep     (in_keep),
      .axis_input_tuser     (in_user),
      .axis_input_tvalid    (in_valid),
      .axis_input_tlast     (in_last),
      .axis_input_tready    (in_ready),
      .axis_output_0_tdata  (o0_data),
      .axis_output_0_tkeep  (o0_keep),
      .axis_output_0_tuser  (o0_user),
      .axis_output_0_tvalid (o0_valid),
      .axis_output_0_tlast  (o0_last),
      .axis_output_0_tready (o0_ready),
      .axis_output_1_tdata  (o1_data),
      .axis_output_1_tkeep  (o1_keep),
      .axis_output_1_tuser  (o1_user),
      .axis_output_1_tvalid (o1_valid),
      .axis_output_1_tlast  (o1_last),
      .axis_output_1_tready (o1_ready),
      .axis_output_2_tdata  (o2_data),
      .axis_output_2_tkeep  (o2_keep),
      .axis_output_2_tuser  (o2_user),
      .axis_output_2_tvalid (o2_valid),
      .axis_output_2_tlast  (o2_last),
      .axis_output_2_tready (o2_ready),
      .packet_count_0       (cnt0),
      .packet_count_1       (cnt1),
      .packet_count_2       (cnt2)
   );

   int n_vec = 0;
   int n_bad = 0;

   int cyc = 0;
   int acc_cnt, stall_cnt, first_stall_acc, first_acc_cyc, first_v0_cyc;
   logic [FW-1:0] q0[$], q1[$], q2[$];

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic last, input logic [TUW-1:0] u,
                                        input logic [TKW-1:0] k, input logic [TDW-1:0] d);
      return {last, u, k, d};
   endfunction

   always @(posedge clk) cyc++;

   // Handshakes are stable across the negative edge, so sample there.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            acc_cnt++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
         end
         if (in_valid && !in_ready) begin
            stall_cnt++;
            if (first_stall_acc < 0) first_stall_acc = acc_cnt;
         end
         if (o0_valid && first_v0_cyc < 0) first_v0_cyc = cyc;
         if (o0_valid && o0_ready) q0.push_back({o0_last, o0_user, o0_keep, o0_data});
         if (o1_valid && o1_ready) q1.push_back({o1_last, o1_user, o1_keep, o1_data});
         if (o2_valid && o2_ready) q2.push_back({o2_last, o2_user, o2_keep, o2_data});
      end
   end

   task automatic clear_mon();
      q0.delete(); q1.delete(); q2.delete();
      acc_cnt = 0; stall_cnt = 0;
      first_stall_acc = -1; first_acc_cyc = -1; first_v0_cyc = -1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      clear_mon();
   endtask

   task automatic send_beat(input logic [TDW-1:0] d, input logic [TKW-1:0] k,
                            input logic [TUW-1:0] u, input logic last);
      bit done = 0;
      in_data = d; in_keep = k; in_user = u; in_last = last; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin done = 1; break; end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (!done) check("input handshake timeout", 0, 1);
   endtask

   task automatic send_pkt(input int nbeats, input logic [TDW-1:0] first);
      for (int i = 0; i < nbeats; i++)
         send_beat(first + TDW'(i), '1, '0, (i == nbeats - 1));
   endtask

   task automatic check_beat(input string tag, input int port, input int idx, input logic [FW-1:0] exp);
      logic [FW-1:0] got;
      got = '1;
      case (port)
         0: if (idx < q0.size()) got = q0[idx];
         1: if (idx < q1.size()) got = q1[idx];
         default: if (idx < q2.size()) got = q2[idx];
      endcase
      check(tag, got, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TDW-1:0] d1, d2;
      clear_mon();
      #1 rst = 1'b1;
      #2;
      check("reset tready", in_ready, 0);
      check("reset tvalid", {o0_valid, o1_valid, o2_valid}, 0);
      check("reset counts", {cnt0, cnt1, cnt2}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      clear_mon();

      // 1: round-robin of three 4-beat packets
      send_pkt(4, 1);
      send_pkt(4, 5);
      send_pkt(4, 9);
      repeat (5) @(posedge clk);
      #1;
      check("t1 q0 size", q0.size(), 4);
      check("t1 q1 size", q1.size(), 4);
      check("t1 q2 size", q2.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check_beat("t1 out0 beat", 0, i, mk(i == 3, '0, '1, TDW'(1 + i)));
         check_beat("t1 out1 beat", 1, i, mk(i == 3, '0, '1, TDW'(5 + i)));
         check_beat("t1 out2 beat", 2, i, mk(i == 3, '0, '1, TDW'(9 + i)));
      end
      check("t1 counts", {cnt0, cnt1, cnt2}, {32'd1, 32'd1, 32'd1});
      check("t1 latency", first_v0_cyc - first_acc_cyc, 2);

      // 2: output 1 stalled, six single-beat packets
      do_reset();
      o1_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_beat(TDW'(1 + i), '1, '0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("t2 q0 size", q0.size(), 2);
      check_beat("t2 out0 a", 0, 0, mk(1, '0, '1, 1));
      check_beat("t2 out0 b", 0, 1, mk(1, '0, '1, 4));
      check("t2 q2 size", q2.size(), 2);
      check_beat("t2 out2 a", 2, 0, mk(1, '0, '1, 3));
      check_beat("t2 out2 b", 2, 1, mk(1, '0, '1, 6));
      check("t2 q1 size", q1.size(), 0);
      check("t2 out1 tvalid", o1_valid, 1);
      check("t2 input stalls", stall_cnt, 0);
      check("t2 count1", cnt1, 2);
      o1_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t2 q1 size", q1.size(), 2);
      check_beat("t2 out1 a", 1, 0, mk(1, '0, '1, 2));
      check_beat("t2 out1 b", 1, 1, mk(1, '0, '1, 5));

      // 3: 20-beat packet into a stalled output 0 (16-entry queue, stall at
      // one free entry: 15 queued + 1 staged accepted before tready drops)
      do_reset();
      o0_ready = 1'b0;
      fork
         send_pkt(20, 1);
         begin
            repeat (30) @(posedge clk);
            #1 o0_ready = 1'b1;
         end
      join
      repeat (25) @(posedge clk);
      #1;
      check("t3 accepted at stall", first_stall_acc, 16);
      check("t3 q0 size", q0.size(), 20);
      for (int i = 0; i < 20; i++)
         check_beat("t3 out0 beat", 0, i, mk(i == 19, '0, '1, TDW'(1 + i)));
      check("t3 others empty", q1.size() + q2.size(), 0);
      check("t3 counts", {cnt0, cnt1, cnt2}, {32'd1, 32'd0, 32'd0});

      // 4: seven single-beat packets
      do_reset();
      for (int i = 0; i < 7; i++) send_beat(TDW'(16 + i), '1, '0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("t4 sizes", {8'(q0.size()), 8'(q1.size()), 8'(q2.size())}, {8'd3, 8'd2, 8'd2});
      check_beat("t4 out0 a", 0, 0, mk(1, '0, '1, 16));
      check_beat("t4 out0 b", 0, 1, mk(1, '0, '1, 19));
      check_beat("t4 out0 c", 0, 2, mk(1, '0, '1, 22));
      check_beat("t4 out1 a", 1, 0, mk(1, '0, '1, 17));
      check_beat("t4 out1 b", 1, 1, mk(1, '0, '1, 20));
      check_beat("t4 out2 a", 2, 0, mk(1, '0, '1, 18));
      check_beat("t4 out2 b", 2, 1, mk(1, '0, '1, 21));
      check("t4 counts", {cnt0, cnt1, cnt2}, {32'd3, 32'd2, 32'd2});

      // 5: asynchronous reset during beat 2 of a packet routed to output 1
      do_reset();
      o1_ready = 1'b0;
      send_beat(TDW'(32), '1, '0, 1'b1);
      send_beat(TDW'(33), '1, '0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("t5 out1 holds beat", o1_valid, 1);
      check("t5 count0 before", cnt0, 1);
      in_data = TDW'(34); in_last = 1'b0; in_valid = 1'b1;
      #3 rst = 1'b1;
      #1;
      check("t5 tvalid after reset", {o0_valid, o1_valid, o2_valid}, 0);
      check("t5 counts after reset", {cnt0, cnt1, cnt2}, 0);
      check("t5 tready in reset", in_ready, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_mon();
      o1_ready = 1'b1;
      send_beat(TDW'(48), '1, '0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("t5 q0 size", q0.size(), 1);
      check_beat("t5 fresh pkt", 0, 0, mk(1, '0, '1, 48));
      check("t5 q1 size", q1.size(), 0);
      check("t5 counts", {cnt0, cnt1, cnt2}, {32'd1, 32'd0, 32'd0});

      // 6: sideband passthrough
      do_reset();
      for (int i = 0; i < 8; i++) begin
         d1[i*32 +: 32] = $urandom;
         d2[i*32 +: 32] = $urandom;
      end
      send_beat(d1, 32'h0000FFFF, {16{8'hA5}}, 1'b1);
      send_beat(d2, 32'hF0F00F0F, {16{8'h5A}}, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check_beat("t6 out0 sideband", 0, 0, mk(1, {16{8'hA5}}, 32'h0000FFFF, d1));
      check_beat("t6 out1 sideband", 1, 0, mk(1, {16{8'h5A}}, 32'hF0F00F0F, d2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
